// File: rtl/idx_list_ctrl_pkg.sv
// idx_list_ctrl_pkg: widths, depth and FSM encodings shared by the index-list controller
package idx_list_ctrl_pkg;
    localparam int IDX_W  = 8;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 32;
    typedef logic [0:0] state_t;
    localparam state_t IDXC_IDLE   = 1'b0;
    localparam state_t IDXC_STREAM = 1'b1;
endpackage

// File: rtl/idx_list_ctrl.sv
// idx_list_ctrl: appends OMP support indices to regfile_idx and streams them back in order
module idx_list_ctrl
    import idx_list_ctrl_pkg::*;
#(
    parameter int IDX_WIDTH  = IDX_W,
    parameter int ADDR_WIDTH = ADDR_W,
    parameter int DEPTH      = idx_list_ctrl_pkg::DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  push_valid,
    output logic                  push_ready,
    input  logic [IDX_WIDTH-1:0]  push_idx,
    input  logic                  rd_start,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [IDX_WIDTH-1:0]  out_idx,
    output logic                  out_last,
    output logic                  done,
    output logic                  busy,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  rf_wr_en,
    output logic                  rf_rd_en,
    output logic [ADDR_WIDTH-1:0] rf_addr,
    output logic [IDX_WIDTH-1:0]  rf_D,
    input  logic [IDX_WIDTH-1:0]  rf_Q
);
    localparam logic [ADDR_WIDTH:0] FULL = (ADDR_WIDTH+1)'(DEPTH);
    state_t                state;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic                  idle, go, last, push_fire, start, adv;
    assign out_idx = rf_Q;
    // a reset or clear cycle must never touch the store
    always_comb begin
        idle       = state == IDXC_IDLE;
        go         = rst & ~clear;
        last       = {1'b0, rd_ptr} == count - 1'b1;
        push_ready = idle & go & ~rd_start & (count < FULL);
        push_fire  = push_valid & push_ready;
        start      = idle & go & rd_start & (count != '0);
        adv        = ~idle & go & out_ready & ~last;
        rf_wr_en   = push_fire;
        rf_rd_en   = start | adv;
        rf_addr    = push_fire ? count[ADDR_WIDTH-1:0] : adv ? rd_ptr + 1'b1 : '0;
        rf_D       = push_fire ? push_idx : '0;
        out_valid  = ~idle;
        busy       = ~idle;
        out_last   = ~idle & last;
    end
    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            state  <= IDXC_IDLE;
            count  <= '0;
            rd_ptr <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (idle) begin
                if (rd_start) begin
                    rd_ptr <= '0;
                    if (count == '0) done <= 1'b1;
                    else state <= IDXC_STREAM;
                end else if (push_fire) begin
                    count <= count + 1'b1;
                end
            end else if (out_ready) begin
                if (last) begin
                    state <= IDXC_IDLE;
                    done  <= 1'b1;
                end else begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_idx_list_ctrl.sv
// tb_idx_list_ctrl: controller plus a regfile_idx store model, scoreboarded writes and readout
module tb_idx_list_ctrl;
    logic       clk = 0, rst = 0, clear = 0, push_valid = 0, rd_start = 0, out_ready = 1;
    logic [7:0] push_idx = 0, out_idx, rf_D, rf_Q;
    logic       push_ready, out_valid, out_last, done, busy, rf_wr_en, rf_rd_en;
    logic [5:0] count;
    logic [4:0] rf_addr;
    logic [7:0] mem [32];
    int exp_wr[$], exp_out[$], stored[$];
    int vectors = 0, miscompares = 0;

    idx_list_ctrl dut (
        .clk(clk), .rst(rst), .clear(clear), .push_valid(push_valid), .push_ready(push_ready),
        .push_idx(push_idx), .rd_start(rd_start), .out_valid(out_valid), .out_ready(out_ready),
        .out_idx(out_idx), .out_last(out_last), .done(done), .busy(busy), .count(count),
        .rf_wr_en(rf_wr_en), .rf_rd_en(rf_rd_en), .rf_addr(rf_addr), .rf_D(rf_D), .rf_Q(rf_Q)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rf_wr_en) mem[rf_addr] <= rf_D;
        if (rf_rd_en) rf_Q <= mem[rf_addr];
    end

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst && !clear) begin
            if (rf_wr_en) begin
                if (exp_wr.size() == 0) chk("unexpected_write", {rf_addr, rf_D}, -1);
                else chk("write", {rf_addr, rf_D}, exp_wr.pop_front());
            end
            if (out_valid && out_ready) begin
                if (exp_out.size() == 0) chk("unexpected_out", {out_last, out_idx}, -1);
                else chk("out", {out_last, out_idx}, exp_out.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input int v);
        push_valid = 1;
        push_idx = 8'(v);
        #1 chk("push_ready", push_ready, 1);
        exp_wr.push_back((stored.size() << 8) | v);
        stored.push_back(v);
        tick();
        push_valid = 0;
    endtask

    task automatic do_clear();
        clear = 1;
        tick();
        clear = 0;
        stored.delete();
        #1 chk("count_after_clear", count, 0);
    endtask

    task automatic readout(input int stall_at, input int stall_n, input bit with_push);
        int n = stored.size();
        for (int i = 0; i < n; i++) exp_out.push_back(((i == n - 1) << 8) | stored[i]);
        out_ready = 1;
        rd_start = 1;
        if (with_push) begin
            push_valid = 1;
            push_idx = 99;
        end
        #1 chk("push_ready_at_start", push_ready, 0);
        chk("rd_en_at_start", rf_rd_en, 1);
        chk("wr_en_at_start", rf_wr_en, 0);
        tick();
        rd_start = 0;
        push_valid = 0;
        for (int i = 0; i < n; i++) begin
            #1 chk("out_valid", out_valid, 1);
            chk("busy", busy, 1);
            if (i == stall_at) begin
                out_ready = 0;
                for (int s = 0; s < stall_n; s++) begin
                    #1 chk("stall_rd_en", rf_rd_en, 0);
                    chk("stall_hold", out_idx, stored[i]);
                    tick();
                    chk("stall_valid", out_valid, 1);
                end
                out_ready = 1;
            end
            tick();
        end
        chk("done", done, 1);
        chk("busy_end", busy, 0);
        chk("valid_end", out_valid, 0);
        tick();
        chk("done_pulse", done, 0);
    endtask

    task automatic abort(input bit use_rst);
        do_clear();
        push_one(1);
        push_one(2);
        push_one(3);
        out_ready = 1;
        rd_start = 1;
        exp_out.push_back(1);
        tick();
        rd_start = 0;
        tick();
        chk("abort_entry1", out_idx, 2);
        chk("abort_valid", out_valid, 1);
        if (use_rst) rst = 0;
        else clear = 1;
        #1 chk("abort_rd_en", rf_rd_en, 0);
        tick();
        rst = 1;
        clear = 0;
        #1 chk("abort_valid_off", out_valid, 0);
        chk("abort_count", count, 0);
        chk("abort_busy", busy, 0);
        chk("abort_last", out_last, 0);
        chk("abort_done", done, 0);
        stored.delete();
        push_one(9);
        push_one(8);
        readout(-1, 0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) tick();
        chk("rst_count", count, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_last", out_last, 0);
        rst = 1;
        push_one(5);
        push_one(17);
        push_one(42);
        #1 chk("count3", count, 3);
        readout(-1, 0, 0);
        readout(1, 2, 0);
        do_clear();
        for (int i = 0; i < 32; i++) push_one(i * 7 + 3);
        #1 chk("count_full", count, 32);
        chk("push_ready_full", push_ready, 0);
        push_valid = 1;
        push_idx = 200;
        repeat (2) tick();
        push_valid = 0;
        chk("count_still_full", count, 32);
        readout(-1, 0, 0);
        do_clear();
        push_one(11);
        push_one(22);
        readout(-1, 0, 1);
        chk("count_after_collide", count, 2);
        do_clear();
        rd_start = 1;
        #1 chk("empty_rd_en", rf_rd_en, 0);
        tick();
        rd_start = 0;
        chk("empty_done", done, 1);
        chk("empty_valid", out_valid, 0);
        tick();
        chk("empty_done_pulse", done, 0);
        chk("empty_valid2", out_valid, 0);
        abort(0);
        abort(1);
        tick();
        chk("wr_queue_empty", exp_wr.size(), 0);
        chk("out_queue_empty", exp_out.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
